// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/nand/compare/equal, iterative one-bit-per-cycle shifts.
// A result is held in output registers until the consumer takes it with out_ready.
module alu_seq #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             illegal
);

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LTU = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_EQ = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;

    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   k;
    logic             k_over;
    logic             shift_over;
    logic             shift_iter;
    logic [WIDTH:0]   sum;

    assign accept = in_valid && in_ready;
    assign k      = data2[SHW-1:0];
    assign sum    = {1'b0, data1} + {1'b0, data2};

    // Only a non-power-of-two WIDTH can encode a k field value that is out of range.
    generate
        if ((1 << SHW) == WIDTH) begin : g_pow2
            assign k_over = 1'b0;
        end else begin : g_npow2
            assign k_over = (32'(k) >= WIDTH);
        end
    endgenerate

    assign is_shift   = (op == OP_SHL) || (op == OP_SHR);
    assign shift_over = ((data2 >> SHW) != '0) || k_over;
    assign shift_iter = is_shift && !shift_over && (k != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
        end
    end

    // A new op is accepted from IDLE or, back-to-back, from DONE while the old result drains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = shift_iter ? SHIFT : DONE;
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        illegal_d = illegal_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        if (accept) begin
            zero_d    = 1'b0;
            carry_d   = 1'b0;
            illegal_d = 1'b0;
            case (op)
                OP_ADD: begin
                    result_d = sum[WIDTH-1:0];
                    carry_d  = sum[WIDTH];
                end
                OP_NAND: result_d = ~(data1 & data2);
                OP_LTU:  result_d = WIDTH'(data1 < data2);
                OP_EQ: begin
                    result_d = '0;
                    zero_d   = (data1 == data2);
                end
                OP_SHL, OP_SHR: begin
                    left_d = (op == OP_SHL);
                    if (shift_over) begin
                        result_d = '0;
                    end else if (k == '0) begin
                        result_d = data1;
                    end else begin
                        result_d = data1;
                        acc_d    = data1;
                        cnt_d    = k;
                    end
                end
                default: begin
                    result_d  = '0;
                    illegal_d = 1'b1;
                end
            endcase
        end else if (state_q == SHIFT) begin
            acc_d    = left_q ? (acc_q << 1) : (acc_q >> 1);
            cnt_d    = cnt_q - SHW'(1);
            result_d = acc_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
        out_valid = (state_q == DONE);
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign carry   = carry_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH = 8: reset, each op, shift latency, backpressure and back-to-back.
// Inputs change and outputs are sampled on the falling edge, away from the active rising edge.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       illegal;

    int tests_run;
    int tests_failed;

    alu_seq #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .data1    (data1),
        .data2    (data2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one op for exactly one cycle; returns on the falling edge after the accepting edge.
    task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        data1    = a;
        data2    = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'b000;
        data1     = 8'h00;
        data2     = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", {out_valid, illegal, zero, carry, result}, 12'h000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        send(3'b100, 8'h01, 8'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL midshift_reset_outputs: got %h expected %h", {out_valid, illegal, zero, carry, result}, 12'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midshift_in_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL midshift_no_valid cycle %0d: got %b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_add();
        send(3'b001, 8'hF0, 8'h20);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1001, 8'h10}) begin
            tests_failed++;
            $display("[TB] FAIL add_carry: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1001, 8'h10});
        end
        send(3'b001, 8'h05, 8'h03);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1000, 8'h08}) begin
            tests_failed++;
            $display("[TB] FAIL add_nocarry: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1000, 8'h08});
        end
    endtask

    task automatic test_compare();
        send(3'b110, 8'h5A, 8'h5A);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1010, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL eq_true: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1010, 8'h00});
        end
        send(3'b110, 8'h5A, 8'h5B);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1000, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL eq_false: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1000, 8'h00});
        end
        send(3'b011, 8'h03, 8'h80);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1000, 8'h01}) begin
            tests_failed++;
            $display("[TB] FAIL ltu_true: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1000, 8'h01});
        end
        send(3'b011, 8'h80, 8'h03);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1000, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL ltu_false: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1000, 8'h00});
        end
        send(3'b010, 8'hFF, 8'h0F);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1000, 8'hF0}) begin
            tests_failed++;
            $display("[TB] FAIL nand: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1000, 8'hF0});
        end
    endtask

    // Iterative shift: out_valid must stay low for exactly k cycles after the accepting edge.
    task automatic test_shift_iter(input logic [2:0] o, input logic [7:0] a, input int k, input logic [7:0] exp);
        send(o, a, 8'(k));
        for (int i = 0; i < k; i++) begin
            tests_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL shift_busy op %b k %0d cycle %0d: got valid %b ready %b expected 0 0", o, k, i, out_valid, in_ready);
            end
            @(negedge clk);
        end
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1000, exp}) begin
            tests_failed++;
            $display("[TB] FAIL shift_result op %b k %0d: got %h expected %h", o, k, {out_valid, illegal, zero, carry, result}, {4'b1000, exp});
        end
    endtask

    task automatic test_shift();
        test_shift_iter(3'b100, 8'h81, 3, 8'h08);
        test_shift_iter(3'b101, 8'h81, 7, 8'h01);
        test_shift_iter(3'b100, 8'hFF, 1, 8'hFE);
        send(3'b100, 8'h81, 8'd8);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1000, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL shift_over8: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1000, 8'h00});
        end
        send(3'b101, 8'h81, 8'h21);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1000, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL shift_highbits: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1000, 8'h00});
        end
        send(3'b100, 8'h81, 8'd0);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1000, 8'h81}) begin
            tests_failed++;
            $display("[TB] FAIL shift_zero: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1000, 8'h81});
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'b010;
        data1     = 8'hFF;
        data2     = 8'h0F;
        @(negedge clk);
        op    = 3'b001;
        data1 = 8'h10;
        data2 = 8'h22;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({in_ready, out_valid, result} !== {2'b01, 8'hF0}) begin
                tests_failed++;
                $display("[TB] FAIL backpressure_hold cycle %0d: got %h expected %h", i, {in_ready, out_valid, result}, {2'b01, 8'hF0});
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_release_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1000, 8'h32}) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_next_add: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1000, 8'h32});
        end
    endtask

    // Ops offered every cycle with out_ready high must each complete one cycle after the previous.
    task automatic test_back_to_back();
        logic [2:0]  ops  [4];
        logic [7:0]  as   [4];
        logic [7:0]  bs   [4];
        logic [11:0] exps [4];
        ops[0] = 3'b001; as[0] = 8'hFF; bs[0] = 8'h01; exps[0] = {4'b1001, 8'h00};
        ops[1] = 3'b010; as[1] = 8'hAA; bs[1] = 8'h0F; exps[1] = {4'b1000, 8'hF5};
        ops[2] = 3'b110; as[2] = 8'h33; bs[2] = 8'h33; exps[2] = {4'b1010, 8'h00};
        ops[3] = 3'b011; as[3] = 8'h7F; bs[3] = 8'h7E; exps[3] = {4'b1000, 8'h00};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            op       = ops[i];
            data1    = as[i];
            data2    = bs[i];
            @(negedge clk);
            tests_run++;
            if ({in_ready, out_valid, illegal, zero, carry, result} !== {1'b1, exps[i]}) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back op %0d: got %h expected %h", i, {in_ready, out_valid, illegal, zero, carry, result}, {1'b1, exps[i]});
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_illegal();
        send(3'b111, 8'h12, 8'h34);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1100, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL illegal_111: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1100, 8'h00});
        end
        send(3'b000, 8'hFF, 8'hFF);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1100, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL illegal_000: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1100, 8'h00});
        end
        send(3'b001, 8'h01, 8'h01);
        tests_run++;
        if ({out_valid, illegal, zero, carry, result} !== {4'b1000, 8'h02}) begin
            tests_failed++;
            $display("[TB] FAIL illegal_cleared: got %h expected %h", {out_valid, illegal, zero, carry, result}, {4'b1000, 8'h02});
        end
        @(negedge clk);
        tests_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_consume: got %b expected 01", {out_valid, in_ready});
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_reset_mid_shift();
        test_add();
        test_compare();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
